// File: rtl/sub_operand_loader_pkg.sv
// Shared definitions for the Substraction operand loader.
//   sub_state_t : loader FSM state encoding
//   SUB_WIDTH   : operand/result width of the Substraction datapath
package sub_operand_loader_pkg;

    localparam int unsigned SUB_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_GET_X  = 2'd0,
        ST_GET_Y  = 2'd1,
        ST_SETTLE = 2'd2,
        ST_OUT    = 2'd3
    } sub_state_t;

endpackage

// File: rtl/sub_operand_loader.sv
// Sequential front/back end for the 4-bit Substraction datapath.
// Takes minuend X then subtrahend Y as consecutive nibbles over a valid/ready
// stream, holds them on the subtractor inputs, waits SETTLE cycles, then
// captures the difference plus a locally computed borrow and offers them over
// a valid/ready result stream.
// Ports:
//   clk, reset                : clock, async active-high reset
//   in_valid/in_data/in_ready : operand nibble stream (X first, then Y)
//   x_out, y_out              : to Substraction x0..x3 / y0..y3 (bit0 = LSB)
//   sub_res                   : from Substraction o0..o3 (bit0 = LSB)
//   res_valid/res_ready       : result stream handshake
//   res_data, res_borrow      : captured X-Y mod 16 and (X < Y)
//   busy                      : high whenever not waiting for X
module sub_operand_loader
    import sub_operand_loader_pkg::*;
#(
    parameter int unsigned WIDTH  = SUB_WIDTH,
    parameter int unsigned SETTLE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic [WIDTH-1:0] x_out,
    output logic [WIDTH-1:0] y_out,
    input  logic [WIDTH-1:0] sub_res,
    output logic             res_valid,
    output logic [WIDTH-1:0] res_data,
    output logic             res_borrow,
    input  logic             res_ready,
    output logic             busy
);

    sub_state_t state, state_next;
    logic [3:0] cnt;
    logic       ld_x, ld_y, cap;

    always_comb begin
        state_next = state;
        ld_x       = 1'b0;
        ld_y       = 1'b0;
        cap        = 1'b0;
        case (state)
            ST_GET_X: if (in_valid) begin
                ld_x       = 1'b1;
                state_next = ST_GET_Y;
            end
            ST_GET_Y: if (in_valid) begin
                ld_y       = 1'b1;
                state_next = ST_SETTLE;
            end
            ST_SETTLE: if (cnt == '0) begin
                cap        = 1'b1;
                state_next = ST_OUT;
            end
            ST_OUT: if (res_ready) begin
                state_next = ST_GET_X;
            end
            default: state_next = ST_GET_X;
        endcase
    end

    // Status outputs decode straight from state so that reset drops
    // res_valid and raises in_ready without waiting for a clock edge.
    assign in_ready  = (state == ST_GET_X) || (state == ST_GET_Y);
    assign res_valid = (state == ST_OUT);
    assign busy      = (state != ST_GET_X);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_GET_X;
            x_out      <= '0;
            y_out      <= '0;
            res_data   <= '0;
            res_borrow <= 1'b0;
            cnt        <= '0;
        end else begin
            state <= state_next;
            if (ld_x) begin
                x_out <= in_data;
            end
            if (ld_y) begin
                y_out <= in_data;
                cnt   <= 4'(SETTLE - 1);
            end else if (state == ST_SETTLE && cnt != '0) begin
                cnt <= cnt - 4'd1;
            end
            if (cap) begin
                res_data   <= sub_res;
                // Borrow comes from the held operands, not from sub_res, so a
                // faulty subtractor still shows up as a data mismatch.
                res_borrow <= (x_out < y_out);
            end
        end
    end

endmodule

// File: tb/tb_sub_operand_loader.sv
// Self-checking bench for sub_operand_loader: models the Substraction
// datapath behaviourally, scoreboards every X/Y pair, and exercises latency,
// back-to-back throughput, output stall, mid-operation reset and SETTLE=3.
module tb_sub_operand_loader;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_ready;
    logic [3:0] x_out, y_out, sub_res;
    logic       res_valid;
    logic [3:0] res_data;
    logic       res_borrow;
    logic       res_ready;
    logic       busy;

    logic       in_valid2;
    logic [3:0] in_data2;
    logic       in_ready2;
    logic [3:0] x_out2, y_out2, sub_res2;
    logic       res_valid2;
    logic [3:0] res_data2;
    logic       res_borrow2;
    logic       res_ready2;
    logic       busy2;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct packed {
        logic       borrow;
        logic [3:0] data;
    } exp_t;
    exp_t sb[$];

    logic tp_mode = 1'b0;
    logic have_prev = 1'b0;
    int   last_pop = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Behavioural Substraction model
    assign sub_res  = x_out - y_out;
    assign sub_res2 = x_out2 - y_out2;

    sub_operand_loader #(.WIDTH(4), .SETTLE(1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .x_out(x_out), .y_out(y_out), .sub_res(sub_res),
        .res_valid(res_valid), .res_data(res_data), .res_borrow(res_borrow),
        .res_ready(res_ready), .busy(busy)
    );

    sub_operand_loader #(.WIDTH(4), .SETTLE(3)) dut3 (
        .clk(clk), .reset(reset), .in_valid(in_valid2), .in_data(in_data2),
        .in_ready(in_ready2), .x_out(x_out2), .y_out(y_out2), .sub_res(sub_res2),
        .res_valid(res_valid2), .res_data(res_data2), .res_borrow(res_borrow2),
        .res_ready(res_ready2), .busy(busy2)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Result monitor: compare each delivered result against the scoreboard.
    always @(negedge clk) begin
        if (!reset && res_valid && res_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_result", 8'd1, 8'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("res_data", {4'd0, res_data}, {4'd0, e.data});
                check("res_borrow", {7'd0, res_borrow}, {7'd0, e.borrow});
            end
            if (tp_mode) begin
                if (have_prev) check("throughput", 8'(cyc - last_pop), 8'd4);
                have_prev = 1'b1;
                last_pop  = cyc;
            end
        end
    end

    task automatic send(input logic [3:0] d);
        int unsigned n = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) check("in_ready_timeout", 8'd0, 8'd1);
        @(posedge clk); #1;
    endtask

    task automatic pair(input logic [3:0] x, input logic [3:0] y);
        exp_t e;
        send(x);
        send(y);
        e.data   = x - y;
        e.borrow = (x < y);
        sb.push_back(e);
    endtask

    task automatic drain();
        int unsigned n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_empty", 8'(sb.size()), 8'd0);
    endtask

    initial begin
        int unsigned n;
        reset = 1'b1; in_valid = 1'b0; in_data = '0; res_ready = 1'b0;
        in_valid2 = 1'b0; in_data2 = '0; res_ready2 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_x_out", {4'd0, x_out}, 8'd0);
        check("rst_y_out", {4'd0, y_out}, 8'd0);
        check("rst_res_data", {4'd0, res_data}, 8'd0);
        check("rst_res_valid", {7'd0, res_valid}, 8'd0);
        check("rst_in_ready", {7'd0, in_ready}, 8'd1);
        check("rst_busy", {7'd0, busy}, 8'd0);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;

        // X=7, Y=3 with latency measurement
        res_ready = 1'b1;
        pair(4'd7, 4'd3);
        in_valid = 1'b0;
        check("x_out_7", {4'd0, x_out}, 8'h07);
        check("y_out_3", {4'd0, y_out}, 8'h03);
        n = 0;
        while (!res_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("latency_settle1", 8'(n), 8'd1);
        drain();

        pair(4'd3, 4'd7);
        pair(4'd9, 4'd9);
        in_valid = 1'b0;
        drain();

        // Exhaustive back-to-back with throughput check
        tp_mode = 1'b1;
        have_prev = 1'b0;
        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++)
                pair(4'(x), 4'(y));
        in_valid = 1'b0;
        drain();
        tp_mode = 1'b0;

        // Output stall with toggling input
        res_ready = 1'b0;
        pair(4'd10, 4'd4);
        n = 0;
        while (!res_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = 4'(i * 5 + 1);
            @(posedge clk); #1;
            check("stall_res_valid", {7'd0, res_valid}, 8'd1);
            check("stall_res_data", {4'd0, res_data}, 8'h06);
            check("stall_x_out", {4'd0, x_out}, 8'h0a);
            check("stall_y_out", {4'd0, y_out}, 8'h04);
            check("stall_in_ready", {7'd0, in_ready}, 8'd0);
        end
        in_valid  = 1'b0;
        res_ready = 1'b1;
        @(posedge clk); #1;
        check("stall_delivered", 8'(sb.size()), 8'd0);

        // Reset while in SETTLE
        pair(4'd5, 4'd2);
        in_valid = 1'b0;
        check("pre_reset_busy", {7'd0, busy}, 8'd1);
        reset = 1'b1;
        void'(sb.pop_back());
        #1;
        check("mid_rst_x_out", {4'd0, x_out}, 8'd0);
        check("mid_rst_y_out", {4'd0, y_out}, 8'd0);
        check("mid_rst_res_data", {4'd0, res_data}, 8'd0);
        check("mid_rst_res_valid", {7'd0, res_valid}, 8'd0);
        check("mid_rst_in_ready", {7'd0, in_ready}, 8'd1);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        pair(4'd1, 4'd1);
        in_valid = 1'b0;
        drain();

        // SETTLE=3 instance: X=8, Y=1
        in_valid2 = 1'b1; in_data2 = 4'd8;
        @(posedge clk); #1;
        in_data2 = 4'd1;
        @(posedge clk); #1;
        in_valid2 = 1'b0;
        n = 0;
        while (!res_valid2 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("latency_settle3", 8'(n), 8'd3);
        check("s3_res_data", {4'd0, res_data2}, 8'h07);
        check("s3_res_borrow", {7'd0, res_borrow2}, 8'd0);
        res_ready2 = 1'b1;
        @(posedge clk); #1;
        check("s3_released", {7'd0, res_valid2}, 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
